// File: rtl/jx2_fpu_cnv_pkg.sv
// Core defines used by the FPU conversion unit: handshake codes, op codes,
// exponent biases and the S2D widening helper.
package jx2_fpu_cnv_pkg;

  localparam logic [1:0] UMEM_OK_READY = 2'd0;
  localparam logic [1:0] UMEM_OK_OK    = 2'd1;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'd2;

  localparam logic [1:0] FPU_CNV_OP_NONE = 2'd0;
  localparam logic [1:0] FPU_CNV_OP_F2I  = 2'd1;
  localparam logic [1:0] FPU_CNV_OP_D2S  = 2'd2;
  localparam logic [1:0] FPU_CNV_OP_S2D  = 2'd3;

  localparam int FPU_EXP_BIAS64 = 1023;
  localparam int FPU_EXP_BIAS32 = 127;

  localparam logic [10:0] FPU_EXP_MAX = 11'h7FF;
  // Biased double exponent of 1.0; below this F2I truncates to zero.
  localparam logic [10:0] FPU_F2I_EXP_ONE  = 11'(FPU_EXP_BIAS64);
  // Exponent at which the 53-bit mantissa is already an integer (no shift).
  localparam logic [10:0] FPU_F2I_EXP_UNIT = 11'(FPU_EXP_BIAS64 + 52);
  // First exponent whose magnitude no longer fits in a signed 64-bit result.
  localparam logic [10:0] FPU_F2I_EXP_SAT  = 11'(FPU_EXP_BIAS64 + 63);
  // Double/single exponent offset; also the D2S flush-to-zero threshold.
  localparam logic [10:0] FPU_EXP_REBIAS   = 11'(FPU_EXP_BIAS64 - FPU_EXP_BIAS32);
  localparam logic [10:0] FPU_D2S_EXP_INF  = 11'(FPU_EXP_BIAS64 - FPU_EXP_BIAS32 + 255);

  // Widen a packed single to double; denormals flush to signed zero.
  function automatic logic [63:0] fpuCnvS2D(input logic [31:0] valSgl);
    logic [7:0] expSgl;
    expSgl = valSgl[30:23];
    if (expSgl == 8'h00)
      fpuCnvS2D = {valSgl[31], 63'b0};
    else if (expSgl == 8'hFF)
      fpuCnvS2D = {valSgl[31], FPU_EXP_MAX, valSgl[22:0], 29'b0};
    else
      fpuCnvS2D = {valSgl[31], {3'b0, expSgl} + FPU_EXP_REBIAS, valSgl[22:0], 29'b0};
  endfunction

endpackage

// File: rtl/jx2_fpu_cnv_shr64.sv
// 64-bit logarithmic barrel right-shifter, 6-bit amount, no sticky output.
module jx2_fpu_cnv_shr64
  import jx2_fpu_cnv_pkg::*;
(
  input  logic [63:0] valIn,
  input  logic [5:0]  shAmt,
  output logic [63:0] valOut
);

  logic [63:0] shTmp;

  // Six conditional power-of-two shift stages.
  always_comb begin
    shTmp = valIn;
    for (int i = 0; i < 6; i++) begin
      if (shAmt[i])
        shTmp = shTmp >> (1 << i);
    end
    valOut = shTmp;
  end

endmodule

// File: rtl/jx2_fpu_cnv.sv
// FPU format conversion unit: F2I (double->int64), D2S (double->single),
// S2D (single->double). Fixed 3-stage pipeline behind the ExOp/ExOK
// request/hold handshake; the requester holds its request until OK.
module jx2_fpu_cnv
  import jx2_fpu_cnv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] regValRn,
  input  logic [1:0]  regExOp,
  output logic [63:0] regValRo,
  output logic [1:0]  regExOK
);

  logic [1:0]  s1Op,  s2Op,  s3Op;
  logic [63:0] s1Val, s2Val, s3Val;
  logic        s1Valid, s2Valid, s3Valid;
  logic [63:0] s2Res;
  logic        s2Neg;

  logic        reqActive;
  logic        reqChange;
  logic        advance;

  logic        s1Sign;
  logic [10:0] s1Exp;
  logic [51:0] s1Frac;
  logic [63:0] s1Mant;
  logic        s1Nan;
  logic [5:0]  shrAmt;
  logic [3:0]  shlAmt;
  logic [63:0] shrOut;
  logic [7:0]  d2sExp8;
  logic [30:0] d2sSum;
  logic [63:0] s2ResNext;
  logic        s2NegNext;

  assign reqActive = (regExOp != FPU_CNV_OP_NONE);
  // A new request invalidates everything behind stage 1 so the pipe refills.
  assign reqChange = (regExOp != s1Op) || (regValRn != s1Val);
  assign advance   = reqActive && !reqChange;

  assign s1Sign = s1Val[63];
  assign s1Exp  = s1Val[62:52];
  assign s1Frac = s1Val[51:0];
  assign s1Mant = {11'b0, 1'b1, s1Frac};
  assign s1Nan  = (s1Exp == FPU_EXP_MAX) && (s1Frac != 52'b0);

  // Only the low bits matter: they are used solely inside the in-range windows.
  assign shrAmt = 6'(FPU_F2I_EXP_UNIT - s1Exp);
  assign shlAmt = 4'(s1Exp - FPU_F2I_EXP_UNIT);

  // Round-half-up on frac[28]; the carry may ripple into the exponent field.
  assign d2sExp8 = 8'(s1Exp - FPU_EXP_REBIAS);
  assign d2sSum  = {d2sExp8, s1Frac[51:29]} + 31'(s1Frac[28]);

  jx2_fpu_cnv_shr64 uShr (
    .valIn  (s1Mant),
    .shAmt  (shrAmt),
    .valOut (shrOut)
  );

  // Stage 2 decode/shift/round; F2I negation is deferred to stage 3.
  always_comb begin
    s2ResNext = 64'b0;
    s2NegNext = 1'b0;
    case (s1Op)
      FPU_CNV_OP_F2I: begin
        if (s1Nan)
          s2ResNext = 64'h8000_0000_0000_0000;
        else if (s1Exp < FPU_F2I_EXP_ONE)
          s2ResNext = 64'b0;
        else if (s1Exp >= FPU_F2I_EXP_SAT)
          s2ResNext = s1Sign ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        else if (s1Exp > FPU_F2I_EXP_UNIT) begin
          s2ResNext = s1Mant << shlAmt;
          s2NegNext = s1Sign;
        end else begin
          s2ResNext = shrOut;
          s2NegNext = s1Sign;
        end
      end
      FPU_CNV_OP_D2S: begin
        if (s1Nan)
          s2ResNext = {32'b0, 32'h7FC0_0000};
        else if (s1Exp == FPU_EXP_MAX)
          s2ResNext = {32'b0, s1Sign, 8'hFF, 23'b0};
        else if (s1Exp <= FPU_EXP_REBIAS)
          s2ResNext = {32'b0, s1Sign, 31'b0};
        else if (s1Exp >= FPU_D2S_EXP_INF)
          s2ResNext = {32'b0, s1Sign, 8'hFF, 23'b0};
        else if (d2sSum[30:23] == 8'hFF)
          s2ResNext = {32'b0, s1Sign, 8'hFF, 23'b0};
        else
          s2ResNext = {32'b0, s1Sign, d2sSum};
      end
      FPU_CNV_OP_S2D: s2ResNext = fpuCnvS2D(s1Val[31:0]);
      default:        s2ResNext = 64'b0;
    endcase
  end

  // Stage 1: capture the request every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1Op    <= 2'b0;
      s1Val   <= 64'b0;
      s1Valid <= 1'b0;
    end else begin
      s1Op    <= regExOp;
      s1Val   <= regValRn;
      s1Valid <= reqActive;
    end
  end

  // Stage 2: register the decoded result alongside the request it belongs to.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2Op    <= 2'b0;
      s2Val   <= 64'b0;
      s2Res   <= 64'b0;
      s2Neg   <= 1'b0;
      s2Valid <= 1'b0;
    end else begin
      s2Op    <= s1Op;
      s2Val   <= s1Val;
      s2Res   <= s2ResNext;
      s2Neg   <= s2NegNext;
      s2Valid <= s1Valid && advance;
    end
  end

  // Stage 3: apply sign and publish; regValRo holds when nothing completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      s3Op     <= 2'b0;
      s3Val    <= 64'b0;
      s3Valid  <= 1'b0;
      regValRo <= 64'b0;
    end else begin
      s3Op    <= s2Op;
      s3Val   <= s2Val;
      s3Valid <= s2Valid && advance;
      if (s2Valid && advance)
        regValRo <= s2Neg ? -s2Res : s2Res;
    end
  end

  // Handshake status: OK only when stage 3 holds exactly the current request.
  always_comb begin
    regExOK = UMEM_OK_HOLD;
    if (!reqActive)
      regExOK = UMEM_OK_READY;
    else if (s3Valid && (s3Op == regExOp) && (s3Val == regValRn))
      regExOK = UMEM_OK_OK;
  end

endmodule

// File: tb/tb_jx2_fpu_cnv.sv
module tb_jx2_fpu_cnv;

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_OK    = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_F2I  = 2'd1;
  localparam logic [1:0] OP_D2S  = 2'd2;
  localparam logic [1:0] OP_S2D  = 2'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] regValRn = 64'b0;
  logic [1:0]  regExOp = 2'b0;
  logic [63:0] regValRo;
  logic [1:0]  regExOK;

  int nVec = 0;
  int nFail = 0;
  logic chkEn = 1'b0;

  // reference model state: edges a request has been stable, last request, expected result
  int          stableCnt = 0;
  logic [65:0] lastReq = '0;
  logic [63:0] expRo = 64'b0;

  jx2_fpu_cnv dut (
    .clock    (clock),
    .reset    (reset),
    .regValRn (regValRn),
    .regExOp  (regExOp),
    .regValRo (regValRo),
    .regExOK  (regExOK)
  );

  always #5 clock = ~clock;

  // conversion rules computed with plain integer arithmetic
  function automatic logic [63:0] refConv(input logic [1:0] op, input logic [63:0] v);
    int          e;
    int          es;
    int          m;
    logic [63:0] mag;
    logic [31:0] sgl;
    int          e8;
    refConv = 64'b0;
    e = int'(v[62:52]);
    if (op == OP_F2I) begin
      if (e == 2047 && v[51:0] != 52'b0) refConv = 64'h8000_0000_0000_0000;
      else if (e < 1023) refConv = 64'b0;
      else if (e >= 1086) refConv = v[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
      else begin
        mag = {11'b0, 1'b1, v[51:0]};
        if (e >= 1075) mag = mag << (e - 1075);
        else mag = mag >> (1075 - e);
        refConv = v[63] ? (64'b0 - mag) : mag;
      end
    end else if (op == OP_D2S) begin
      es = e - 896;
      if (e == 2047 && v[51:0] != 52'b0) refConv = 64'h0000_0000_7FC0_0000;
      else if (e == 2047 || es >= 255) refConv = {32'b0, v[63], 8'hFF, 23'b0};
      else if (es <= 0) refConv = {32'b0, v[63], 31'b0};
      else begin
        m = int'(v[51:29]) + int'(v[28]);
        if (m == (1 << 23)) begin
          m = 0;
          es = es + 1;
        end
        if (es >= 255) refConv = {32'b0, v[63], 8'hFF, 23'b0};
        else refConv = {32'b0, v[63], 8'(es), 23'(m)};
      end
    end else if (op == OP_S2D) begin
      sgl = v[31:0];
      e8 = int'(sgl[30:23]);
      if (e8 == 0) refConv = {sgl[31], 63'b0};
      else if (e8 == 255) refConv = {sgl[31], 11'h7FF, sgl[22:0], 29'b0};
      else refConv = {sgl[31], 11'(e8 + 896), sgl[22:0], 29'b0};
    end
  endfunction

  // model update on each active edge
  always @(posedge clock) begin
    if (reset) begin
      stableCnt = 0;
      lastReq = '0;
      expRo = 64'b0;
    end else if (regExOp == OP_NONE) begin
      stableCnt = 0;
      lastReq = '0;
    end else begin
      if ({regExOp, regValRn} == lastReq) stableCnt = stableCnt + 1;
      else stableCnt = 1;
      lastReq = {regExOp, regValRn};
      if (stableCnt >= 3) expRo = refConv(regExOp, regValRn);
    end
  end

  // continuous compare against the model on the falling edge
  always @(negedge clock) begin
    logic [1:0] expOk;
    if (chkEn) begin
      if (regExOp == OP_NONE) expOk = ST_READY;
      else if (stableCnt >= 3 && {regExOp, regValRn} == lastReq) expOk = ST_OK;
      else expOk = ST_HOLD;
      nVec++;
      if (regExOK !== expOk) begin
        nFail++;
        $display("FAIL model_exok t=%0t got=%0d want=%0d", $time, regExOK, expOk);
      end
      nVec++;
      if (regValRo !== expRo) begin
        nFail++;
        $display("FAIL model_valro t=%0t got=%h want=%h", $time, regValRo, expRo);
      end
    end
  end

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chkOk(input string name, input int cyc, input logic [1:0] exp);
    nVec++;
    if (regExOK !== exp) begin
      nFail++;
      $display("FAIL %s cycle %0d exok got=%0d want=%0d", name, cyc, regExOK, exp);
    end
  endtask

  task automatic runVec(input logic [1:0] op, input logic [63:0] v, input logic [63:0] expLit,
                        input string name);
    chk64({name, "_model"}, refConv(op, v), expLit);
    @(posedge clock); #1;
    regExOp = op;
    regValRn = v;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chkOk(name, c, (c < 3) ? ST_HOLD : ST_OK);
      if (c == 3) chk64(name, regValRo, expLit);
    end
    @(posedge clock); #1;
    regExOp = OP_NONE;
    @(negedge clock);
    chkOk({name, "_idle"}, 0, ST_READY);
    chk64({name, "_hold"}, regValRo, expLit);
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clock); #1;
    chkEn = 1'b1;
    @(negedge clock);
    chk64("reset_valro", regValRo, 64'b0);
    chkOk("reset_exok", 0, ST_READY);
    @(posedge clock); #1;
    reset = 1'b0;

    runVec(OP_F2I, 64'h4059_0000_0000_0000, 64'h0000_0000_0000_0064, "f2i_100");
    runVec(OP_F2I, 64'hC05E_C000_0000_0000, 64'hFFFF_FFFF_FFFF_FF85, "f2i_m123");
    runVec(OP_F2I, 64'h43E0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, "f2i_sat_pos");
    runVec(OP_F2I, 64'hC3E0_0000_0000_0001, 64'h8000_0000_0000_0000, "f2i_sat_neg");
    runVec(OP_F2I, 64'h3FE0_0000_0000_0000, 64'h0000_0000_0000_0000, "f2i_half");
    runVec(OP_F2I, 64'hBFF8_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "f2i_m1p5");
    runVec(OP_F2I, 64'h43DF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FC00, "f2i_e1085");
    runVec(OP_F2I, 64'h7FF8_0000_0000_0000, 64'h8000_0000_0000_0000, "f2i_nan");
    runVec(OP_D2S, 64'h3FF0_0000_0000_0000, 64'h0000_0000_3F80_0000, "d2s_one");
    runVec(OP_D2S, 64'h7E37_E43C_8800_759C, 64'h0000_0000_7F80_0000, "d2s_ovf");
    runVec(OP_D2S, 64'h7FF8_0000_0000_0000, 64'h0000_0000_7FC0_0000, "d2s_nan");
    runVec(OP_D2S, 64'h3800_0000_0000_0000, 64'h0000_0000_0000_0000, "d2s_flush");
    runVec(OP_D2S, 64'h3FFF_FFFF_F000_0000, 64'h0000_0000_4000_0000, "d2s_rndcarry");
    runVec(OP_D2S, 64'h47EF_FFFF_F000_0000, 64'h0000_0000_7F80_0000, "d2s_rnd_inf");
    runVec(OP_D2S, 64'hC000_0000_0000_0000, 64'h0000_0000_C000_0000, "d2s_m2");
    runVec(OP_D2S, 64'hFFF0_0000_0000_0000, 64'h0000_0000_FF80_0000, "d2s_minf");
    runVec(OP_S2D, 64'h0000_0000_4049_0FDB, 64'h4009_21FB_6000_0000, "s2d_pi");
    runVec(OP_S2D, 64'h0000_0000_FF80_0000, 64'hFFF0_0000_0000_0000, "s2d_minf");
    runVec(OP_S2D, 64'hDEAD_BEEF_3F80_0000, 64'h3FF0_0000_0000_0000, "s2d_one_hi");
    runVec(OP_S2D, 64'h0000_0000_8000_0001, 64'h8000_0000_0000_0000, "s2d_denorm");

    // op switch one cycle into a request restarts the latency
    @(posedge clock); #1;
    regExOp = OP_F2I;
    regValRn = 64'h3FF0_0000_0000_0000;
    @(negedge clock);
    chkOk("switch", 0, ST_HOLD);
    @(posedge clock); #1;
    regExOp = OP_D2S;
    for (int c = 1; c < 6; c++) begin
      @(negedge clock);
      chkOk("switch", c, (c < 4) ? ST_HOLD : ST_OK);
      if (c == 4) chk64("switch_val", regValRo, 64'h0000_0000_3F80_0000);
    end
    @(posedge clock); #1;
    regExOp = OP_NONE;

    // reset pulse in cycle 2 of a held F2I request
    @(posedge clock); #1;
    regExOp = OP_F2I;
    regValRn = 64'h4059_0000_0000_0000;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
        reset = (c == 2);
      end
      @(negedge clock);
      chkOk("rst_mid", c, (c < 6) ? ST_HOLD : ST_OK);
      if (c == 3) chk64("rst_mid_valro0", regValRo, 64'b0);
      if (c == 6) chk64("rst_mid_val", regValRo, 64'h0000_0000_0000_0064);
    end
    @(posedge clock); #1;
    regExOp = OP_NONE;
    @(negedge clock);
    chkEn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/jx2_fpu_cnv.md
Name: jx2_fpu_cnv

Overview:
- Multi-cycle FPU format-conversion unit, downstream of the FPU adder.
- Consumes 64-bit double results and converts them to int64 (F2I) or to packed single (D2S); also widens single operands to double (S2D) ahead of the adder.
- Uses the same ExOp/ExOK request/hold handshake and the UMEM_OK_* codes from the core defines.
- Fixed 3-stage pipeline.

Parameters:
- None. All widths are fixed: 64-bit data, 2-bit op, 2-bit status.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- regValRn  in  64  source operand
- regExOp  in  2  0=none, 1=F2I, 2=D2S, 3=S2D
- regValRo  out  64  conversion result; registered
- regExOK  out  2  UMEM_OK_READY(0) / UMEM_OK_OK(1) / UMEM_OK_HOLD(2); combinational from pipeline state

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset values:
  - regValRo = 0.
  - All stage-valid bits are 0.
  - Captured op/value registers are 0.
- ExOK:
  - READY when regExOp==0.
  - Otherwise OK when stage-3 valid and the stage-3 captured {op,value} equals the current {regExOp,regValRn}.
  - Otherwise HOLD.
- Requester holds op/value stable until OK. Latency: OK is first asserted 3 cycles after a stable request is first presented.
- Pipeline:
  - Stage 1 registers {op,value} every cycle; valid = op!=0.
  - Stage 2 decodes, shifts and rounds.
  - Stage 3 packs the result into regValRo and stage3-valid.
- Request change while op!=0 (op or value differs from the stage-1 capture): stage 2/3 valid bits clear that cycle and the pipeline refills, so OK comes 3 cycles after the change.
- op==0: all valid bits clear; regValRo holds its last value.
- Reset mid-operation: valid bits clear. If op is still nonzero after reset deasserts, ExOK=HOLD and the 3-cycle count restarts.
- F2I (double to int64, truncate toward zero):
  - Biased exp e < 1023 → 0.
  - 1023 ≤ e ≤ 1085 → mantissa (hidden 1) shifted right by 1075−e (or left when e>1075), then negated if sign.
  - e ≥ 1086 with finite input → saturate to 0x7FFF_FFFF_FFFF_FFFF (+) or 0x8000_0000_0000_0000 (−).
  - NaN → 0x8000_0000_0000_0000.
- D2S (double to single, result in bits [31:0], bits [63:32] = 0):
  - Rebias es = e − 896.
  - Mantissa = frac[51:29], rounded up when frac[28]=1 (round-half-up, same as the adder). A rounding carry propagates into the exponent.
  - es ≤ 0 → signed zero (flush; no denormals).
  - es ≥ 255 or rounded exponent == 255 → signed Inf.
  - Inf → signed Inf.
  - NaN → 0x7FC0_0000.
- S2D (single in [31:0] to double; [63:32] ignored):
  - Exp 0 → signed zero (denormals flushed).
  - Exp 255 → exp 2047, frac = frac32<<29 (Inf/NaN preserved).
  - Otherwise exp + 896, frac = frac32<<29.
- No exceptions or flags are produced; the FAULT status code is never driven.

Decomposition:
- Shared core defines package (existing file) supplies:
  - UMEM_OK_READY / OK / HOLD
  - new constants FPU_CNV_OP_NONE / F2I / D2S / S2D
  - FPU_EXP_BIAS64 = 1023, FPU_EXP_BIAS32 = 127
- One natural sub-module: jx2_fpu_cnv_shr64, a 64-bit barrel right-shifter with a sticky-free 6-bit amount. It is used by the F2I stage 2; D2S and S2D need only fixed shifts.

Test Plan:
- F2I 0x4059_0000_0000_0000 (100.0) held from cycle 0 → ExOK = HOLD in cycles 0–2, OK in cycle 3, regValRo = 0x0000_0000_0000_0064.
- F2I 0xC05E_C000_0000_0000 (−123.0) → 0xFFFF_FFFF_FFFF_FF85; 0x43E0_0000_0000_0000 (2^63) → 0x7FFF_FFFF_FFFF_FFFF; 0x3FE0_0000_0000_0000 (0.5) → 0.
- D2S:
  - 0x3FF0_0000_0000_0000 → 0x0000_0000_3F80_0000
  - 0x7E37_E43C_8800_759C → 0x7F80_0000
  - 0x7FF8_0000_0000_0000 → 0x7FC0_0000
  - 0x3800_0000_0000_0000 → 0 (underflow flush)
- S2D 0x4049_0FDB → 0x4009_21FB_6000_0000; 0xFF80_0000 → 0xFFF0_0000_0000_0000.
- Op switch: F2I 1.0 at cycle 0, switched to D2S 1.0 at cycle 1 → no OK at cycle 3; OK at cycle 4 with 0x3F80_0000.
- Reset pulse at cycle 2 of an F2I request held throughout → ExOK = HOLD; regValRo = 0 after reset; OK 3 cycles after reset deasserts with the correct result.
